image_byte_packer: RTL

Upstream feeder for `spi_master`: it accepts a stream of 24-bit RGB pixels from the vision pipeline and converts each pixel to RGB565. It frames each image as sync bytes, pixel bytes and an XOR checksum. Bytes are buffered in a small FIFO and presented one at a time on the `image_byte_data` / `image_data_valid` / `image_transmitted` handshake that `spi_master` consumes.

---
 rtl/img_spi_pkg.sv | 39 +++
 rtl/image_byte_packer_if.sv | 29 ++
 rtl/byte_fifo.sv | 53 +++++
 rtl/image_byte_packer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/img_spi_pkg.sv
// Shared types and helpers for the pixel-to-SPI byte packer: sync bytes,
// FSM encodings, FIFO entry layout and the RGB888 -> RGB565 conversion.
package img_spi_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PIX_HI,
    PIX_LO,
    ACCEPT,
    CSUM
  } in_state_e;

  typedef enum logic [1:0] {
    O_IDLE,
    O_WAIT,
    O_GAP
  } out_state_e;

  // One FIFO slot: last marks the checksum byte that closes a frame.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  typedef struct packed {
    logic        eop;
    logic [15:0] rgb;
  } hold_t;

  function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/image_byte_packer_if.sv
// Pixel-stream input and SPI byte handshake of the image byte packer.
// The packer is the slave; the pixel source / SPI master side is the master.
interface image_byte_packer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [23:0]   pix_data;
  logic          pix_valid;
  logic          pix_sop;
  logic          pix_eop;
  logic          pix_ready;
  logic [7:0]    image_byte_data;
  logic          image_data_valid;
  logic          image_transmitted;
  logic [LW-1:0] fifo_level;
  logic          frame_sent;

  modport slave (
    input  pix_data, pix_valid, pix_sop, pix_eop, image_transmitted,
    output pix_ready, image_byte_data, image_data_valid, fifo_level, frame_sent
  );

  modport master (
    output pix_data, pix_valid, pix_sop, pix_eop, image_transmitted,
    input  pix_ready, image_byte_data, image_data_valid, fifo_level, frame_sent
  );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous single-clock FIFO; pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter.
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is deliberately left out of reset; only the pointers define
  // which entries are valid, so clearing the array would cost logic for nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rdata_o = mem[rd_ptr_q[AW-1:0]];
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));

endmodule

// File: rtl/image_byte_packer.sv
// Frames RGB888 pixel streams as A5 5A <RGB565 bytes> <XOR checksum> and hands
// the bytes one at a time to spi_master through a small FIFO.
module image_byte_packer
  import img_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  image_byte_packer_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  in_state_e   in_state_q;
  hold_t       hold_q;
  logic [7:0]  csum_q;
  logic        pending_q;
  logic        pix_ready_q;

  out_state_e  out_state_q;
  fifo_entry_t out_q;
  logic        valid_q;
  logic        trans_q;
  logic        frame_sent_q;

  logic        push;
  logic        push_ok;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pix_acc;
  logic        trans_rise;
  fifo_entry_t push_entry;
  fifo_entry_t pop_entry;
  hold_t       pix_hold;
  logic [LW-1:0] level;

  assign pix_acc    = bus.pix_valid && pix_ready_q;
  assign pix_hold   = '{eop: bus.pix_eop, rgb: rgb888_to_565(bus.pix_data)};
  assign push_ok    = push && !fifo_full;
  assign trans_rise = bus.image_transmitted && !trans_q;
  assign pop        = (out_state_q == O_IDLE) && !fifo_empty;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    push       = 1'b0;
    push_entry = '{last: 1'b0, data: 8'h00};
    unique case (in_state_q)
      HDR0:    begin push = 1'b1; push_entry.data = SYNC0;          end
      HDR1:    begin push = 1'b1; push_entry.data = SYNC1;          end
      PIX_HI:  begin push = 1'b1; push_entry.data = hold_q.rgb[15:8]; end
      PIX_LO:  begin push = 1'b1; push_entry.data = hold_q.rgb[7:0];  end
      CSUM:    begin push = 1'b1; push_entry = '{last: 1'b1, data: csum_q}; end
      default: ;
    endcase
  end

  // Input FSM: push states stall while the FIFO is full; pix_ready is
  // registered and only high in IDLE/ACCEPT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q  <= IDLE;
      hold_q      <= '0;
      csum_q      <= 8'h00;
      pending_q   <= 1'b0;
      pix_ready_q <= 1'b0;
    end else begin
      unique case (in_state_q)
        IDLE: begin
          if (pix_acc && bus.pix_sop) begin
            hold_q      <= pix_hold;
            csum_q      <= 8'h00;
            pix_ready_q <= 1'b0;
            in_state_q  <= HDR0;
          end else begin
            pix_ready_q <= 1'b1;
          end
        end
        HDR0:   if (push_ok) in_state_q <= HDR1;
        HDR1:   if (push_ok) in_state_q <= PIX_HI;
        PIX_HI: begin
          if (push_ok) begin
            csum_q     <= csum_q ^ hold_q.rgb[15:8];
            in_state_q <= PIX_LO;
          end
        end
        PIX_LO: begin
          if (push_ok) begin
            csum_q <= csum_q ^ hold_q.rgb[7:0];
            if (hold_q.eop) begin
              in_state_q <= CSUM;
            end else begin
              in_state_q  <= ACCEPT;
              pix_ready_q <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (pix_acc) begin
            hold_q      <= pix_hold;
            pix_ready_q <= 1'b0;
            // A new SOP mid-frame closes the old frame before starting over.
            if (bus.pix_sop) begin
              pending_q  <= 1'b1;
              in_state_q <= CSUM;
            end else begin
              in_state_q <= PIX_HI;
            end
          end
        end
        CSUM: begin
          if (push_ok) begin
            if (pending_q) begin
              pending_q  <= 1'b0;
              csum_q     <= 8'h00;
              in_state_q <= HDR0;
            end else begin
              pix_ready_q <= 1'b1;
              in_state_q  <= IDLE;
            end
          end
        end
        default: begin
          pix_ready_q <= 1'b0;
          in_state_q  <= IDLE;
        end
      endcase
    end
  end

  // Output FSM: only a rising edge of image_transmitted consumes a byte, so a
  // level left high from the previous byte cannot retire the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_state_q  <= O_IDLE;
      out_q        <= '0;
      valid_q      <= 1'b0;
      trans_q      <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      trans_q      <= bus.image_transmitted;
      frame_sent_q <= 1'b0;
      unique case (out_state_q)
        O_IDLE: begin
          if (!fifo_empty) begin
            out_q       <= pop_entry;
            valid_q     <= 1'b1;
            out_state_q <= O_WAIT;
          end
        end
        O_WAIT: begin
          if (trans_rise) begin
            valid_q      <= 1'b0;
            frame_sent_q <= out_q.last;
            out_state_q  <= O_GAP;
          end
        end
        O_GAP:   out_state_q <= O_IDLE;
        default: out_state_q <= O_IDLE;
      endcase
    end
  end

  byte_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push_ok),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (pop_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign bus.pix_ready        = pix_ready_q;
  assign bus.image_byte_data  = out_q.data;
  assign bus.image_data_valid = valid_q;
  assign bus.fifo_level       = level;
  assign bus.frame_sent       = frame_sent_q;

endmodule
